extram_arbiter: RTL and testbench
=================================

Name: extram_arbiter

Overview:
- Shares the single external-RAM port (word address, byte write enables, 32-bit data, busy/pause) between two requesters: master 0 = CPU, master 1 = DMA/debug loader.
- Sits between the CPU external-memory pins and the external RAM model/controller, in the same clock domain as the CPU.
- Serialises accesses with one-outstanding-transaction handshakes, a fixed CPU preference and a fairness cap so master 1 cannot starve.

Parameters:
- ADDR_W, 30, word-address width (address bits 31:2)
- DATA_W, 32, data width; byte_we width is DATA_W/8
- CPU_MAX_CONSEC, 4, max back-to-back master-0 grants while master 1 is pending; range 1..15

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  CPU access request; held with m0_* stable until completion
- m0_addr  in  ADDR_W  CPU word address
- m0_byte_we  in  DATA_W/8  CPU byte enables; 0 = read
- m0_wdata  in  DATA_W  CPU write data
- m0_rdata  out  DATA_W  read data, valid while m0_pause is low after a request
- m0_pause  out  1  stall to CPU; m0_req & ~(completing for master 0)
- m1_req  in  1  master-1 request; held until m1_ack
- m1_addr  in  ADDR_W  master-1 word address
- m1_byte_we  in  DATA_W/8  master-1 byte enables; 0 = read
- m1_wdata  in  DATA_W  master-1 write data
- m1_rdata  out  DATA_W  read data, valid in the m1_ack cycle
- m1_ack  out  1  one-cycle completion pulse
- ram_address  out  ADDR_W  address to RAM, registered
- ram_byte_we  out  DATA_W/8  byte enables to RAM, registered
- ram_data_write  out  DATA_W  write data to RAM, registered
- ram_data_read  in  DATA_W  read data from RAM
- ram_pause  in  1  RAM busy; access is incomplete while high

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, grant=0, ram_address=0, ram_byte_we=0, ram_data_write=0, m0_rdata=0, m1_rdata=0, m1_ack=0, fairness counter=0. m0_pause follows m0_req.
- FSM states:
  - IDLE: if any request, pick a winner, register its addr/byte_we/wdata onto ram_*, set grant, go to ACCESS. Otherwise stay in IDLE with ram_byte_we=0 and ram_address holding its last value.
  - ACCESS: ram_* outputs held. When ram_pause=0, capture ram_data_read into the winner's rdata register, clear ram_byte_we, go to RESP. While ram_pause=1, stay.
  - RESP: signal completion for one cycle (m0_pause low for master 0, or m1_ack=1 for master 1), go to IDLE.
- Latency: request sampled in IDLE at cycle N gives completion at N+2 with zero RAM wait, plus one cycle per ram_pause=1 cycle in ACCESS.
- Back-to-back throughput: one access per 3 cycles.
- Arbitration:
  - Master 0 wins by default when both request.
  - Fairness counter increments on each master-0 grant while m1_req=1, and clears on a master-1 grant or when m1_req=0.
  - When the counter equals CPU_MAX_CONSEC and both request, master 1 wins.
- A request that drops before its completion is a protocol violation. The arbiter still finishes the RAM access and completes normally.
- For writes, the rdata register is still updated with ram_data_read. Its value is don't-care.
- Reset mid-ACCESS: next edge forces IDLE and ram_byte_we=0. No completion is issued.

Optional Feature:
- Macro: EXTRAM_ARB_STATS_EN.
- When defined, adds these ports:
  - stat_clr in 1
  - stat_m0_cnt out 16
  - stat_m1_cnt out 16
  - stat_m1_wait out 16
- Counter behaviour:
  - stat_m0_cnt and stat_m1_cnt increment per completion of the respective master.
  - stat_m1_wait increments every cycle m1_req=1 without m1_ack.
  - All counters saturate at 0xFFFF and clear on reset or stat_clr. stat_clr wins over a simultaneous increment.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package extram_arb_pkg: state enum (IDLE, ACCESS, RESP), grant encoding (GNT_M0=0, GNT_M1=1), stats counter width constant.
- One sub-module: extram_arb_pick. It holds the fairness counter and the winner-select logic, taking the req inputs and grant events and producing the winner.

Test Plan:
- m0 read of addr 0x10, RAM returns 0xDEADBEEF with ram_pause=0 -> m0_pause low at N+2, m0_rdata=0xDEADBEEF, ram_byte_we stays 0.
- m1 write addr 0x20, data 0x12345678, byte_we=0xF, ram_pause high 3 cycles -> ram_byte_we=0xF for 4 ACCESS cycles, m1_ack pulses once at N+5.
- m0 and m1 requesting continuously, CPU_MAX_CONSEC=4 -> grant order m0,m0,m0,m0,m1 repeating; stats (if enabled) show stat_m0_cnt=8, stat_m1_cnt=2 after 10 accesses.
- Simultaneous requests with an idle history -> m0 served first, m1_ack 3 cycles after m0 completes.
- reset asserted in ACCESS with ram_byte_we=0x3 -> next cycle ram_byte_we=0, state IDLE, no m1_ack/m0 completion.
- EXTRAM_ARB_STATS_EN: stat_clr coinciding with m1_ack -> stat_m1_cnt=0; hold m1_req pending 70000 cycles -> stat_m1_wait=0xFFFF.

Source files
------------

// File: rtl/extram_arb_pkg.sv
// Shared types and constants for the external-RAM arbiter: FSM states, grant
// encoding, counter widths and a saturating increment helper.
package extram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_t;

  localparam int STAT_W = 16;
  localparam int FAIR_W = 4;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/extram_arbiter_if.sv
// Bus bundle for the arbiter: both requester ports plus the shared RAM port.
// slave = arbiter view, master = environment (CPU, DMA and RAM) view.
interface extram_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [BE_W-1:0]   m0_byte_we;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_pause;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [BE_W-1:0]   m1_byte_we;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byte_we;
  logic [DATA_W-1:0] ram_data_write;
  logic [DATA_W-1:0] ram_data_read;
  logic              ram_pause;

  modport slave (
    input  m0_req, m0_addr, m0_byte_we, m0_wdata,
    output m0_rdata, m0_pause,
    input  m1_req, m1_addr, m1_byte_we, m1_wdata,
    output m1_rdata, m1_ack,
    output ram_address, ram_byte_we, ram_data_write,
    input  ram_data_read, ram_pause
  );

  modport master (
    output m0_req, m0_addr, m0_byte_we, m0_wdata,
    input  m0_rdata, m0_pause,
    output m1_req, m1_addr, m1_byte_we, m1_wdata,
    input  m1_rdata, m1_ack,
    input  ram_address, ram_byte_we, ram_data_write,
    output ram_data_read, ram_pause
  );
endinterface

// File: rtl/extram_arb_pick.sv
// Winner selection: CPU preferred, but after CPU_MAX_CONSEC CPU grants taken
// while master 1 waits, master 1 is forced through.
module extram_arb_pick
  import extram_arb_pkg::*;
#(
  parameter int CPU_MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_m0_req,
  input  logic i_m1_req,
  input  logic i_grant_en,
  output gnt_t o_winner
);

  localparam logic [FAIR_W-1:0] MAX_C = FAIR_W'(CPU_MAX_CONSEC);

  logic [FAIR_W-1:0] r_cnt;
  logic              w_force_m1;

  assign w_force_m1 = (r_cnt == MAX_C);
  assign o_winner   = (i_m1_req && (!i_m0_req || w_force_m1)) ? GNT_M1 : GNT_M0;

  // Count only CPU grants that actually made master 1 wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_m1_req) begin
      r_cnt <= '0;
    end else if (i_grant_en) begin
      if (o_winner == GNT_M1) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/extram_arbiter.sv
// Two-master arbiter for the single external-RAM port (CPU = master 0).
// Optional usage counters are built when EXTRAM_ARB_STATS_EN is defined.
module extram_arbiter
  import extram_arb_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int CPU_MAX_CONSEC = 4
) (
  input logic clk,
  input logic reset,
  extram_arbiter_if.slave bus
`ifdef EXTRAM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_m0_cnt,
  output logic [STAT_W-1:0] stat_m1_cnt,
  output logic [STAT_W-1:0] stat_m1_wait
`endif
);

  localparam int BE_W = DATA_W / 8;

  state_t            r_state;
  gnt_t              r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic              r_m0_done;
  logic              r_m1_ack;

  logic              w_grant_en;
  gnt_t              w_winner;

  assign w_grant_en = (r_state == IDLE) && (bus.m0_req || bus.m1_req);

  extram_arb_pick #(
    .CPU_MAX_CONSEC(CPU_MAX_CONSEC)
  ) u_pick (
    .clk       (clk),
    .reset     (reset),
    .i_m0_req  (bus.m0_req),
    .i_m1_req  (bus.m1_req),
    .i_grant_en(w_grant_en),
    .o_winner  (w_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= GNT_M0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_m0_done  <= 1'b0;
      r_m1_ack   <= 1'b0;
    end else begin
      r_m0_done <= 1'b0;
      r_m1_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_be <= '0;
          if (w_grant_en) begin
            r_grant <= w_winner;
            if (w_winner == GNT_M1) begin
              r_addr  <= bus.m1_addr;
              r_be    <= bus.m1_byte_we;
              r_wdata <= bus.m1_wdata;
            end else begin
              r_addr  <= bus.m0_addr;
              r_be    <= bus.m0_byte_we;
              r_wdata <= bus.m0_wdata;
            end
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!bus.ram_pause) begin
            // Read data is captured for writes too; the requester ignores it.
            if (r_grant == GNT_M1) begin
              r_m1_rdata <= bus.ram_data_read;
            end else begin
              r_m0_rdata <= bus.ram_data_read;
            end
            r_be      <= '0;
            r_m0_done <= (r_grant == GNT_M0);
            r_m1_ack  <= (r_grant == GNT_M1);
            r_state   <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_address    = r_addr;
  assign bus.ram_byte_we    = r_be;
  assign bus.ram_data_write = r_wdata;
  assign bus.m0_rdata       = r_m0_rdata;
  assign bus.m1_rdata       = r_m1_rdata;
  assign bus.m1_ack         = r_m1_ack;
  assign bus.m0_pause       = bus.m0_req & ~r_m0_done;

`ifdef EXTRAM_ARB_STATS_EN
  logic [STAT_W-1:0] r_st_m0;
  logic [STAT_W-1:0] r_st_m1;
  logic [STAT_W-1:0] r_st_wait;

  // Clear has priority over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      r_st_m0   <= '0;
      r_st_m1   <= '0;
      r_st_wait <= '0;
    end else begin
      if (r_m0_done) r_st_m0 <= sat_inc(r_st_m0);
      if (r_m1_ack) r_st_m1 <= sat_inc(r_st_m1);
      if (bus.m1_req && !r_m1_ack) r_st_wait <= sat_inc(r_st_wait);
    end
  end

  assign stat_m0_cnt  = r_st_m0;
  assign stat_m1_cnt  = r_st_m1;
  assign stat_m1_wait = r_st_wait;
`endif

endmodule

// File: tb/tb_extram_arbiter.sv
// Bench for extram_arbiter: directed scenarios, then random traffic checked
// against a transaction-level model of arbitration, latency and RAM contents.
module tb_extram_arbiter;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int MAXC   = 4;
  localparam int BOUND  = 200;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  logic [DATA_W-1:0] mem [64];
  logic [DATA_W-1:0] exp_mem [64];

  extram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef EXTRAM_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_m0_cnt;
  logic [15:0] stat_m1_cnt;
  logic [15:0] stat_m1_wait;
`endif

  extram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_MAX_CONSEC(MAXC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef EXTRAM_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_m0_cnt (stat_m0_cnt),
    .stat_m1_cnt (stat_m1_cnt),
    .stat_m1_wait(stat_m1_wait)
`endif
  );

  assign bus.ram_data_read = mem[bus.ram_address[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM commits a write at the edge where it is not busy; then step to next negedge.
  task automatic nxt();
    if (bus.ram_byte_we != '0 && !bus.ram_pause) begin
      for (int i = 0; i < 4; i++)
        if (bus.ram_byte_we[i]) mem[bus.ram_address[5:0]][8*i +: 8] = bus.ram_data_write[8*i +: 8];
    end
    @(negedge clk);
  endtask

  // Model state for the random phase: arbiter free / RAM access / completion.
  int                ph;
  int                fc;
  logic              win;
  logic              p0, p1;
  logic [ADDR_W-1:0] a0, a1, ta;
  logic [3:0]        b0, b1, tbe;
  logic [DATA_W-1:0] w0, w1, tw;
  int                wt0, wt1;
  int                k;
  logic              who;

  initial begin
    n_chk = 0; n_err = 0;
    reset = 1'b1;
    bus.m0_req = 0; bus.m0_addr = '0; bus.m0_byte_we = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_addr = '0; bus.m1_byte_we = '0; bus.m1_wdata = '0;
    bus.ram_pause = 0;
`ifdef EXTRAM_ARB_STATS_EN
    stat_clr = 0;
`endif
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (3) nxt();

    chk("rst_addr", 64'(bus.ram_address), 0);
    chk("rst_be", 64'(bus.ram_byte_we), 0);
    chk("rst_wdata", 64'(bus.ram_data_write), 0);
    chk("rst_m0_rdata", 64'(bus.m0_rdata), 0);
    chk("rst_m1_rdata", 64'(bus.m1_rdata), 0);
    chk("rst_m1_ack", 64'(bus.m1_ack), 0);
    chk("rst_m0_pause_lo", 64'(bus.m0_pause), 0);
    bus.m0_req = 1; #1;
    chk("rst_m0_pause_hi", 64'(bus.m0_pause), 1);
    bus.m0_req = 0;
    reset = 1'b0;
    nxt();

    // CPU read, no RAM wait
    mem[6'h10] = 32'hDEADBEEF;
    bus.m0_req = 1; bus.m0_addr = 30'h10; bus.m0_byte_we = 4'h0; bus.ram_pause = 0;
    nxt();
    chk("t1_pause_acc", 64'(bus.m0_pause), 1);
    chk("t1_addr", 64'(bus.ram_address), 64'h10);
    chk("t1_be_acc", 64'(bus.ram_byte_we), 0);
    nxt();
    chk("t1_pause_done", 64'(bus.m0_pause), 0);
    chk("t1_rdata", 64'(bus.m0_rdata), 64'hDEADBEEF);
    chk("t1_be_done", 64'(bus.ram_byte_we), 0);
    bus.m0_req = 0;
    nxt();

    // master-1 write with three RAM wait cycles
    bus.m1_req = 1; bus.m1_addr = 30'h20; bus.m1_wdata = 32'h12345678; bus.m1_byte_we = 4'hF;
    nxt();
    chk("t2_be_acc", 64'(bus.ram_byte_we), 64'hF);
    chk("t2_addr", 64'(bus.ram_address), 64'h20);
    chk("t2_wdata", 64'(bus.ram_data_write), 64'h12345678);
    chk("t2_ack_acc", 64'(bus.m1_ack), 0);
    bus.ram_pause = 1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("t2_be_wait", 64'(bus.ram_byte_we), 64'hF);
      chk("t2_ack_wait", 64'(bus.m1_ack), 0);
      if (i == 2) bus.ram_pause = 0;
    end
    nxt();
    chk("t2_ack", 64'(bus.m1_ack), 1);
    chk("t2_be_done", 64'(bus.ram_byte_we), 0);
    chk("t2_mem", 64'(mem[6'h20]), 64'h12345678);
`ifdef EXTRAM_ARB_STATS_EN
    stat_clr = 1;
`endif
    bus.m1_req = 0;
    nxt();
    chk("t2_ack_pulse", 64'(bus.m1_ack), 0);
`ifdef EXTRAM_ARB_STATS_EN
    chk("t2_stat_clr", 64'(stat_m1_cnt), 0);
    stat_clr = 0;
`endif
    nxt();

    // both masters requesting continuously
    bus.m0_req = 1; bus.m0_addr = 30'h1; bus.m0_byte_we = 0;
    bus.m1_req = 1; bus.m1_addr = 30'h2; bus.m1_byte_we = 0;
    k = 0;
    for (int c = 0; c < 80 && k < 10; c++) begin
      nxt();
      if (!bus.m0_pause || bus.m1_ack) begin
        who = bus.m1_ack;
        chk($sformatf("t3_order%0d", k), 64'(who), 64'((k % 5) == 4));
        k++;
        if (k == 10) begin bus.m0_req = 0; bus.m1_req = 0; end
      end
    end
    chk("t3_count", 64'(k), 10);
    bus.m0_req = 0; bus.m1_req = 0;
    nxt();
`ifdef EXTRAM_ARB_STATS_EN
    chk("t3_stat_m0", 64'(stat_m0_cnt), 8);
    chk("t3_stat_m1", 64'(stat_m1_cnt), 2);
`endif
    repeat (3) nxt();

    // simultaneous requests from idle
    bus.m0_req = 1; bus.m0_addr = 30'h5; bus.m1_req = 1; bus.m1_addr = 30'h6;
    nxt(); nxt();
    chk("t4_m0_done", 64'(bus.m0_pause), 0);
    chk("t4_m1_not_first", 64'(bus.m1_ack), 0);
    bus.m0_req = 0;
    for (int i = 0; i < 2; i++) begin
      nxt();
      chk("t4_ack_early", 64'(bus.m1_ack), 0);
    end
    nxt();
    chk("t4_ack", 64'(bus.m1_ack), 1);
    chk("t4_m1_rdata", 64'(bus.m1_rdata), 64'(mem[6'h6]));
    bus.m1_req = 0;
    nxt();

    // reset during ACCESS
    bus.m1_req = 1; bus.m1_addr = 30'h7; bus.m1_byte_we = 4'h3; bus.m1_wdata = 32'hA5A5A5A5;
    bus.ram_pause = 1;
    nxt();
    chk("t5_be_acc", 64'(bus.ram_byte_we), 64'h3);
    reset = 1'b1;
    nxt();
    chk("t5_be_rst", 64'(bus.ram_byte_we), 0);
    chk("t5_no_ack", 64'(bus.m1_ack), 0);
    reset = 1'b0; bus.ram_pause = 0;
    nxt();
    chk("t5_restart_be", 64'(bus.ram_byte_we), 64'h3);
    chk("t5_restart_ack", 64'(bus.m1_ack), 0);
    nxt();
    chk("t5_ack", 64'(bus.m1_ack), 1);
    bus.m1_req = 0; bus.m1_byte_we = 0;
    nxt();

`ifdef EXTRAM_ARB_STATS_EN
    // master 1 kept waiting behind a stalled CPU access
    bus.m0_req = 1; bus.m1_req = 1; bus.ram_pause = 1;
    repeat (70000) nxt();
    chk("t6_wait_sat", 64'(stat_m1_wait), 64'hFFFF);
    bus.m0_req = 0; bus.m1_req = 0;
`endif

    // random traffic against the model
    reset = 1'b1; bus.m0_req = 0; bus.m1_req = 0; bus.ram_pause = 0;
    repeat (2) nxt();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) exp_mem[i] = mem[i];
    ph = 0; fc = 0; win = 0; p0 = 0; p1 = 0; wt0 = 0; wt1 = 0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; w0 = '0; w1 = '0;
    for (int c = 0; c < 3400; c++) begin
      chk("r_m1_ack", 64'(bus.m1_ack), 64'(ph == 2 && win));
      chk("r_m0_pause", 64'(bus.m0_pause), 64'(p0 && !(ph == 2 && !win)));
      ta = win ? a1 : a0; tbe = win ? b1 : b0; tw = win ? w1 : w0;
      chk("r_ram_be", 64'(bus.ram_byte_we), (ph == 1) ? 64'(tbe) : 64'h0);
      if (ph != 0) chk("r_ram_addr", 64'(bus.ram_address), 64'(ta));
      if (ph == 1 && tbe != 0) chk("r_ram_wdata", 64'(bus.ram_data_write), 64'(tw));
      if (ph == 2) begin
        if (tbe == 0) begin
          if (win) chk("r_m1_rdata", 64'(bus.m1_rdata), 64'(exp_mem[ta[5:0]]));
          else     chk("r_m0_rdata", 64'(bus.m0_rdata), 64'(exp_mem[ta[5:0]]));
        end else begin
          for (int i = 0; i < 4; i++)
            if (tbe[i]) exp_mem[ta[5:0]][8*i +: 8] = tw[8*i +: 8];
        end
        if (win) begin chk("r_m1_wait_bound", 64'(wt1 <= BOUND), 1); p1 = 0; wt1 = 0; end
        else     begin chk("r_m0_wait_bound", 64'(wt0 <= BOUND), 1); p0 = 0; wt0 = 0; end
      end
      if (p0) wt0++;
      if (p1) wt1++;
      if (c < 3000) begin
        if (!p0 && $urandom_range(0, 2) == 0) begin
          p0 = 1; a0 = 30'($urandom_range(0, 63)); w0 = $urandom;
          b0 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        end
        if (!p1 && $urandom_range(0, 2) == 0) begin
          p1 = 1; a1 = 30'($urandom_range(0, 63)); w1 = $urandom;
          b1 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        end
      end
      bus.m0_req = p0; bus.m0_addr = a0; bus.m0_byte_we = b0; bus.m0_wdata = w0;
      bus.m1_req = p1; bus.m1_addr = a1; bus.m1_byte_we = b1; bus.m1_wdata = w1;
      bus.ram_pause = ($urandom_range(0, 3) == 0);
      // arbitration rules applied at the coming edge
      if (ph == 0) begin
        if (p0 || p1) begin
          win = p1 && (!p0 || fc == MAXC);
          if (win) fc = 0;
          else if (p1) fc++;
          ph = 1;
        end
      end else if (ph == 1) begin
        if (!bus.ram_pause) ph = 2;
      end else begin
        ph = 0;
      end
      if (!p1) fc = 0;
      nxt();
    end
    chk("r_drained", 64'(p0 || p1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
